pcs_block_sync: RTL and testbench
=================================

Name: pcs_block_sync

Overview:
Receive-side 64b/66b block synchroniser, the counterpart to the transmit path's sync-header generation. It watches the 2-bit sync header delivered once per 66-bit block by the RX gearbox. It runs the Clause 49 lock state machine and requests bit slips from the gearbox until header alignment is found. Its o_block_lock output drives the decoder's i_block_lock input.

Parameters:
HDR_WIDTH, 2, sync header width
SH_CNT_MAX, 64, headers per evaluation window
SH_INVALID_MAX, 16, invalid headers in a window that force loss of lock
SLIP_WAIT_CYCLES, 32, clock cycles ignored after a slip while the gearbox realigns

Ports:
i_clk  in  1  core clock
i_reset_n  in  1  asynchronous active-low reset
i_rx_hdr  in  HDR_WIDTH  sync header from the gearbox; sampled only when i_rx_hdr_valid=1
i_rx_hdr_valid  in  1  header qualifier; nominally high every other cycle (one 66b block = two 32-bit beats)
o_block_lock  out  1  registered lock indication to the decoder
o_rx_slip  out  1  one-cycle pulse asking the gearbox to slip one bit
o_sh_invalid  out  1  one-cycle pulse per invalid header sampled (status/debug)

Behaviour:
- Reset (async, active-low):
  - o_block_lock=0, o_rx_slip=0, o_sh_invalid=0.
  - sh_cnt=0, sh_invalid_cnt=0, state=TEST.
  - Deassertion takes effect on the next i_clk edge.
- Header validity: 2'b01 and 2'b10 are valid; 2'b00 and 2'b11 are invalid. i_rx_hdr is ignored when i_rx_hdr_valid=0.
- Counter widths: $clog2(SH_CNT_MAX+1) and $clog2(SH_INVALID_MAX+1).
- All outputs are registered; each decision appears on the cycle after the deciding header is sampled.
- State TEST:
  - On each qualified header: sh_cnt+1; if the header is invalid, sh_invalid_cnt+1 and o_sh_invalid pulses.
  - Unlocked, invalid header: go to SLIP immediately (no window completion needed).
  - Unlocked, header that brings sh_cnt to SH_CNT_MAX with sh_invalid_cnt==0: o_block_lock=1; clear both counters; stay in TEST.
  - Locked, sh_invalid_cnt reaches SH_INVALID_MAX (on any header, before or at window end): o_block_lock=0; go to SLIP.
  - Locked, sh_cnt reaches SH_CNT_MAX with sh_invalid_cnt<SH_INVALID_MAX: clear both counters; stay locked.
  - If the same header both completes the window and is the SH_INVALID_MAX-th invalid header, loss of lock wins.
- State SLIP: exactly one cycle.
  - o_rx_slip=1; clear counters; o_block_lock=0; load the wait counter with SLIP_WAIT_CYCLES-1; go to SLIP_WAIT.
  - Headers sampled in this cycle are dropped (not counted, no o_sh_invalid).
- State SLIP_WAIT:
  - Decrement the wait counter each cycle; all headers are ignored.
  - When the counter reaches 0, return to TEST with counters at 0.
  - o_rx_slip is never re-asserted during the wait, so slips are spaced by at least SLIP_WAIT_CYCLES+1 cycles.
- i_rx_hdr_valid gaps (held low for many cycles) are legal; counters simply hold.
- Reset asserted mid-window or mid-wait: immediate return to reset values; no o_rx_slip is emitted on reset exit.

Decomposition:
- Shared package pcs_pkg:
  - SYNC_HDR_DATA=2'b01 and SYNC_HDR_CTRL=2'b10 constants, shared with the encoder and decoder.
  - block_sync_state_t enum {TEST, SLIP, SLIP_WAIT}.
  - Function is_valid_sh(hdr).
- No sub-module: a single FSM with three counters.

Test Plan:
- Reset, then 64 headers of 01/10 alternating with i_rx_hdr_valid toggling every cycle -> o_block_lock=0 through the 64th header, 1 on the following cycle, no o_rx_slip.
- Unlocked, header #10 = 2'b00 -> o_sh_invalid and o_rx_slip each pulse once, one cycle apart as specified. The next 32 cycles of headers (including 2'b11) produce no pulses. Then 64 valid headers -> lock.
- Locked, 15 invalid headers (2'b11) spread across a 64-header window -> o_block_lock stays 1; next window starts clean (a further 15 invalid still do not drop lock).
- Locked, 16 invalid headers by header #40 -> o_block_lock falls the cycle after the 16th; o_rx_slip pulses once; headers #41-#64 are ignored during SLIP_WAIT.
- Locked, pull i_reset_n low mid-window for 1 cycle, asynchronously to i_clk -> o_block_lock=0 immediately. After release, 64 valid headers are needed to relock; no slip is emitted.
- Loopback: encoder -> pcs_block_sync -> xgmii_decoder with i_block_lock driven by o_block_lock. After lock, decoded frames match transmitted frames word-for-word.

Source files
------------

// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared 64b/66b PCS constants, block sync state type and header check
package pcs_pkg;

    localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
    localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        TEST      = 2'd0,
        SLIP      = 2'd1,
        SLIP_WAIT = 2'd2
    } block_sync_state_t;

    function automatic logic is_valid_sh(input logic [1:0] hdr);
        return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
    endfunction

endpackage

// File: rtl/pcs_block_sync.sv
// rtl/pcs_block_sync.sv - 64b/66b receive block lock state machine with gearbox slip requests
module pcs_block_sync
    import pcs_pkg::*;
#(
    parameter int HDR_WIDTH        = 2,
    parameter int SH_CNT_MAX       = 64,
    parameter int SH_INVALID_MAX   = 16,
    parameter int SLIP_WAIT_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [HDR_WIDTH-1:0] i_rx_hdr,
    input  logic                 i_rx_hdr_valid,
    output logic                 o_block_lock,
    output logic                 o_rx_slip,
    output logic                 o_sh_invalid
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT_CYCLES > 1) ? $clog2(SLIP_WAIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT_CYCLES - 1);

    block_sync_state_t state;
    logic [CNT_W-1:0]  sh_cnt;
    logic [INV_W-1:0]  sh_invalid_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              hdr_ok;
    logic [CNT_W-1:0]  cnt_next;
    logic [INV_W-1:0]  inv_next;

    always_comb begin
        hdr_ok   = is_valid_sh(i_rx_hdr);
        cnt_next = sh_cnt + CNT_W'(1);
        inv_next = hdr_ok ? sh_invalid_cnt : sh_invalid_cnt + INV_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= TEST;
            sh_cnt         <= '0;
            sh_invalid_cnt <= '0;
            wait_cnt       <= '0;
            o_block_lock   <= 1'b0;
            o_rx_slip      <= 1'b0;
            o_sh_invalid   <= 1'b0;
        end else begin
            o_rx_slip    <= 1'b0;
            o_sh_invalid <= 1'b0;
            case (state)
                TEST: begin
                    if (i_rx_hdr_valid) begin
                        o_sh_invalid   <= ~hdr_ok;
                        sh_cnt         <= cnt_next;
                        sh_invalid_cnt <= inv_next;
                        if (!o_block_lock && !hdr_ok) begin
                            state <= SLIP;
                        end else if (o_block_lock && (inv_next == INV_LAST)) begin
                            // Loss of lock takes priority over a window that completes on the same header.
                            o_block_lock <= 1'b0;
                            state        <= SLIP;
                        end else if (cnt_next == CNT_LAST) begin
                            // Unlocked windows only get here with zero invalid headers.
                            o_block_lock   <= 1'b1;
                            sh_cnt         <= '0;
                            sh_invalid_cnt <= '0;
                        end
                    end
                end
                SLIP: begin
                    o_rx_slip      <= 1'b1;
                    o_block_lock   <= 1'b0;
                    sh_cnt         <= '0;
                    sh_invalid_cnt <= '0;
                    wait_cnt       <= WAIT_LOAD;
                    state          <= SLIP_WAIT;
                end
                SLIP_WAIT: begin
                    if (wait_cnt == '0) begin
                        sh_cnt         <= '0;
                        sh_invalid_cnt <= '0;
                        state          <= TEST;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                default: begin
                    state <= TEST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcs_block_sync.sv
// tb/tb_pcs_block_sync.sv - scoreboard bench for pcs_block_sync lock, slip and reset behaviour
module tb_pcs_block_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] rx_hdr = 2'b00;
    logic       rx_hdr_valid = 1'b0;
    logic       block_lock;
    logic       rx_slip;
    logic       sh_invalid;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] h;
    } stim_t;

    typedef struct packed {
        logic l;
        logic s;
        logic i;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    pcs_block_sync dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_rx_hdr       (rx_hdr),
        .i_rx_hdr_valid (rx_hdr_valid),
        .o_block_lock   (block_lock),
        .o_rx_slip      (rx_slip),
        .o_sh_invalid   (sh_invalid)
    );

    function automatic logic [1:0] good_hdr(input int k);
        return (k % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic push(input logic v, input logic [1:0] h, input logic l, input logic s, input logic i);
        stim_q.push_back('{v: v, h: h});
        exp_q.push_back('{l: l, s: s, i: i});
    endtask

    // 64 valid headers back-to-back from an unlocked, clean window; lock shows after the last.
    task automatic push_relock();
        for (int k = 0; k < 64; k++) push(1'b1, good_hdr(k), k == 63, 1'b0, 1'b0);
    endtask

    // Slip cycle (its header is dropped) followed by 32 ignored cycles of garbage headers.
    task automatic push_slip_and_wait();
        push(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) push(1'b1, (k % 2 == 0) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_hdr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t ex;
        stim_t st;
        apply_reset();
        rst_n = 1'b0;
        #1;
        compared++;
        if ({block_lock, rx_slip, sh_invalid} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_hold: lock/slip/inv=%b expected 000", {block_lock, rx_slip, sh_invalid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL reset_exit: lock/slip/inv=%b expected %b", {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
    endtask

    task automatic test_lock_toggling();
        exp_t ex;
        stim_t st;
        apply_reset();
        for (int k = 0; k < 64; k++) begin
            push(1'b1, good_hdr(k), k == 63, 1'b0, 1'b0);
            push(1'b0, 2'b00, k == 63, 1'b0, 1'b0);
        end
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL lock_toggling[%0d]: lock/slip/inv=%b expected %b", 128 - stim_q.size(), {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
    endtask

    task automatic test_tolerate_invalid();
        exp_t ex;
        stim_t st;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 64; k++) begin
                if (k % 4 == 1 && k < 60) push(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
                else push(1'b1, good_hdr(k), 1'b1, 1'b0, 1'b0);
            end
        end
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL tolerate15[%0d]: lock/slip/inv=%b expected %b", 128 - stim_q.size(), {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
    endtask

    task automatic test_loss_of_lock();
        exp_t ex;
        stim_t st;
        for (int k = 1; k <= 40; k++) begin
            if (k >= 25) push(1'b1, 2'b11, k != 40, 1'b0, 1'b1);
            else push(1'b1, good_hdr(k), 1'b1, 1'b0, 1'b0);
        end
        push_slip_and_wait();
        push_relock();
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL loss_of_lock[%0d]: lock/slip/inv=%b expected %b", 137 - stim_q.size(), {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t ex;
        stim_t st;
        for (int k = 0; k < 20; k++) push(1'b1, good_hdr(k), 1'b1, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL pre_reset[%0d]: lock/slip/inv=%b expected %b", 20 - stim_q.size(), {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (block_lock !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_lock: lock=%b expected 0", block_lock);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        // Relock needs a full clean window even when split by a long valid gap.
        for (int k = 0; k < 30; k++) push(1'b1, good_hdr(k), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) push(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int k = 30; k < 64; k++) push(1'b1, good_hdr(k), k == 63, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL post_reset_relock[%0d]: lock/slip/inv=%b expected %b", 164 - stim_q.size(), {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
    endtask

    task automatic test_slip_unlocked();
        exp_t ex;
        stim_t st;
        apply_reset();
        for (int k = 1; k <= 9; k++) push(1'b1, good_hdr(k), 1'b0, 1'b0, 1'b0);
        push(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        push_slip_and_wait();
        push_relock();
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(negedge clk);
            rx_hdr_valid = st.v;
            rx_hdr = st.h;
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            compared++;
            if ({block_lock, rx_slip, sh_invalid} !== {ex.l, ex.s, ex.i}) begin
                mismatched++;
                $display("FAIL slip_unlocked[%0d]: lock/slip/inv=%b expected %b", 107 - stim_q.size(), {block_lock, rx_slip, sh_invalid}, {ex.l, ex.s, ex.i});
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_toggling();
        test_tolerate_invalid();
        test_loss_of_lock();
        test_async_reset();
        test_slip_unlocked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
